// File: rtl/host_cfg_sequencer_pkg.sv
// Shared definitions for the host configuration sequencer.
//
// Purpose:
//   Host-controller word geometry and the sequencer FSM state encoding,
//   shared by the sequencer top and the testbench.
//
// Contents:
//   PE_INST    - width of the PE instruction field
//   INIT_PE_A  - width of the init_PE_array field
//   H_C_W      - full host_controller word width
//                {init_SPM, init_PE_array, inst}
//   seq_state_t - FSM state encoding
package host_cfg_sequencer_pkg;

    localparam int PE_INST   = 32;
    localparam int INIT_PE_A = 15;
    localparam int H_C_W     = 1 + INIT_PE_A + PE_INST;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        GAP_WAIT = 3'd2,
        RUN      = 3'd3,
        DONE     = 3'd4
    } seq_state_t;

endpackage

// File: rtl/host_cfg_sequencer_cfg_entry_ram.sv
// Config-entry store for the host configuration sequencer.
//
// Purpose:
//   Simple dual-port RAM with one write port and one synchronous read
//   port. The read register forwards same-cycle write data when the read
//   and write addresses match. The sequencer relies on this so that an
//   entry written in the cycle before a start is seen at once.
//   The storage array has no reset.
//
// Ports:
//   clk      - clock, rising edge
//   wr_en    - write strobe
//   wr_addr  - write index
//   wr_data  - write data
//   rd_addr  - read index, sampled every cycle
//   rd_data  - registered read data, valid one cycle after rd_addr
module cfg_entry_ram #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 48,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        // Write-first forwarding keeps the read register coherent with a
        // write to the address currently being read.
        if (wr_en && (wr_addr == rd_addr)) begin
            rd_data <= wr_data;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/host_cfg_sequencer.sv
// Host configuration sequencer.
//
// Purpose:
//   Buffers config entries written by the host. On start, it replays the
//   entries back-to-back on host_controller. It then idles host_controller
//   for GAP cycles, pulses run for one cycle and pulses done for one cycle.
//   The buffer is retained, so a later start replays the same sequence.
//
// Ports:
//   clk             - clock, rising edge
//   rst             - synchronous active-high reset
//   cfg_wr_en       - append one entry (IDLE only)
//   cfg_wr_data     - entry {init_SPM, init_PE_array, inst}
//   cfg_clear       - empty the buffer and clear ovf (IDLE only)
//   start           - request a replay (IDLE only)
//   host_controller - registered entry drive, zero outside ISSUE
//   run             - registered one-cycle run strobe
//   busy            - sequence in progress
//   done            - one-cycle completion pulse
//   ovf             - sticky: a write was dropped on a full buffer
//   cnt             - number of stored entries
module host_cfg_sequencer
    import host_cfg_sequencer_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int GAP   = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_wr_en,
    input  logic [H_C_W-1:0]         cfg_wr_data,
    input  logic                     cfg_clear,
    input  logic                     start,
    output logic [H_C_W-1:0]         host_controller,
    output logic                     run,
    output logic                     busy,
    output logic                     done,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    seq_state_t       state;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    issue_idx;
    logic [GW-1:0]    gap_cnt;
    logic [AW-1:0]    rd_addr;
    logic [H_C_W-1:0] rd_data;
    logic             wr_accept;
    logic             start_accept;

    // Input qualification and read-address pre-issue. Outside ISSUE, the
    // RAM is parked on entry 0, so entry 0 is already in the read register
    // when start arrives. On the start cycle, the address jumps to 1.
    // During ISSUE, rd_ptr runs one entry ahead of the entry being
    // latched, so consecutive entries come out without bubbles.
    always_comb begin
        start_accept = (state == IDLE) && !cfg_clear && start;
        wr_accept    = !rst && (state == IDLE) && !cfg_clear && !start &&
                       cfg_wr_en && (cnt < CW'(DEPTH));
        rd_addr      = '0;
        if (state == ISSUE) begin
            rd_addr = rd_ptr;
        end else if (start_accept) begin
            rd_addr = AW'(1);
        end
    end

    cfg_entry_ram #(
        .DEPTH (DEPTH),
        .WIDTH (H_C_W),
        .AW    (AW)
    ) u_cfg_entry_ram (
        .clk     (clk),
        .wr_en   (wr_accept),
        .wr_addr (cnt[AW-1:0]),
        .wr_data (cfg_wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Sequencer FSM with registered outputs. Buffer-management inputs are
    // honoured only in IDLE. cfg_clear beats start, and start beats
    // cfg_wr_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            ovf             <= 1'b0;
            host_controller <= '0;
            run             <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            rd_ptr          <= '0;
            issue_idx       <= '0;
            gap_cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    host_controller <= '0;
                    run             <= 1'b0;
                    done            <= 1'b0;
                    if (cfg_clear) begin
                        cnt <= '0;
                        ovf <= 1'b0;
                    end else if (start) begin
                        if (cnt != '0) begin
                            state           <= ISSUE;
                            busy            <= 1'b1;
                            host_controller <= rd_data;
                            rd_ptr          <= AW'(2);
                            issue_idx       <= '0;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else if (cfg_wr_en) begin
                        if (cnt < CW'(DEPTH)) begin
                            cnt <= cnt + CW'(1);
                        end else begin
                            ovf <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    // issue_idx names the entry currently on host_controller.
                    if ({1'b0, issue_idx} == (cnt - CW'(1))) begin
                        host_controller <= '0;
                        gap_cnt         <= '0;
                        if (GAP == 0) begin
                            state <= RUN;
                            run   <= 1'b1;
                        end else begin
                            state <= GAP_WAIT;
                        end
                    end else begin
                        host_controller <= rd_data;
                        issue_idx       <= issue_idx + AW'(1);
                        rd_ptr          <= rd_ptr + AW'(1);
                    end
                end

                GAP_WAIT: begin
                    host_controller <= '0;
                    if (gap_cnt == GW'(GAP - 1)) begin
                        state <= RUN;
                        run   <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end

                RUN: begin
                    host_controller <= '0;
                    run             <= 1'b0;
                    busy            <= 1'b0;
                    done            <= 1'b1;
                    state           <= DONE;
                end

                DONE: begin
                    host_controller <= '0;
                    done            <= 1'b0;
                    state           <= IDLE;
                end

                default: begin
                    host_controller <= '0;
                    run             <= 1'b0;
                    busy            <= 1'b0;
                    done            <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_host_cfg_sequencer.sv
// Self-checking testbench for host_cfg_sequencer.
//
// Purpose:
//   Directed scenarios with hand-computed expectations: reset, empty
//   start, full replay timing, back-to-back replays, ignored inputs while
//   busy, write/start collision, overflow/clear and reset during ISSUE.
//   Inputs are driven and outputs are sampled on the falling edge.
module tb_host_cfg_sequencer;

    localparam int DEPTH = 32;
    localparam int GAP   = 3;
    localparam int W     = 48;

    logic         clk;
    logic         rst;
    logic         cfg_wr_en;
    logic [W-1:0] cfg_wr_data;
    logic         cfg_clear;
    logic         start;
    logic [W-1:0] host_controller;
    logic         run;
    logic         busy;
    logic         done;
    logic         ovf;
    logic [5:0]   cnt;

    int checks;
    int failures;

    logic [W-1:0] exp_words [0:10];

    host_cfg_sequencer #(
        .DEPTH (DEPTH),
        .GAP   (GAP)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_wr_en       (cfg_wr_en),
        .cfg_wr_data     (cfg_wr_data),
        .cfg_clear       (cfg_clear),
        .start           (start),
        .host_controller (host_controller),
        .run             (run),
        .busy            (busy),
        .done            (done),
        .ovf             (ovf),
        .cnt             (cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drives one entry for one cycle.
    task automatic write_entry(input logic [W-1:0] data);
        cfg_wr_en   = 1'b1;
        cfg_wr_data = data;
        @(negedge clk);
        cfg_wr_en   = 1'b0;
        cfg_wr_data = '0;
    endtask

    task automatic pulse_clear();
        cfg_clear = 1'b1;
        @(negedge clk);
        cfg_clear = 1'b0;
    endtask

    task automatic load_eleven();
        for (int i = 0; i < 11; i++) begin
            write_entry(exp_words[i]);
        end
    endtask

    // Checks that all outputs are idle and that cnt and ovf match.
    task automatic check_idle(input string tag, input logic [5:0] exp_cnt, input logic exp_ovf);
        checks++;
        if (host_controller !== '0) begin
            failures++;
            $display("[TB] FAIL %s host_controller got=%h exp=0", tag, host_controller);
        end
        checks++;
        if (run !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s run got=%b exp=0", tag, run);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s busy got=%b exp=0", tag, busy);
        end
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s done got=%b exp=0", tag, done);
        end
        checks++;
        if (cnt !== exp_cnt) begin
            failures++;
            $display("[TB] FAIL %s cnt got=%0d exp=%0d", tag, cnt, exp_cnt);
        end
        checks++;
        if (ovf !== exp_ovf) begin
            failures++;
            $display("[TB] FAIL %s ovf got=%b exp=%b", tag, ovf, exp_ovf);
        end
    endtask

    // Starts a replay of the first n exp_words and checks every cycle from
    // t+1 to t+n+GAP+2. With disturb set, the task pulses cfg_wr_en,
    // cfg_clear and start during ISSUE and again during GAP_WAIT.
    task automatic run_replay(input int n, input bit disturb, input string tag);
        logic [W-1:0] exp_hc;
        logic         exp_run;
        logic         exp_done;
        logic         exp_busy;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= n + GAP + 2; k++) begin
            exp_hc   = (k <= n) ? exp_words[k-1] : '0;
            exp_run  = (k == n + GAP + 1);
            exp_done = (k == n + GAP + 2);
            exp_busy = (k <= n + GAP + 1);
            checks++;
            if (host_controller !== exp_hc) begin
                failures++;
                $display("[TB] FAIL %s host_controller t+%0d got=%h exp=%h", tag, k, host_controller, exp_hc);
            end
            checks++;
            if (run !== exp_run) begin
                failures++;
                $display("[TB] FAIL %s run t+%0d got=%b exp=%b", tag, k, run, exp_run);
            end
            checks++;
            if (done !== exp_done) begin
                failures++;
                $display("[TB] FAIL %s done t+%0d got=%b exp=%b", tag, k, done, exp_done);
            end
            checks++;
            if (busy !== exp_busy) begin
                failures++;
                $display("[TB] FAIL %s busy t+%0d got=%b exp=%b", tag, k, busy, exp_busy);
            end
            if (disturb && (k == 2 || k == n + 2)) begin
                cfg_wr_en   = 1'b1;
                cfg_wr_data = 48'hdead_beef_0001;
                cfg_clear   = 1'b1;
                start       = 1'b1;
            end else begin
                cfg_wr_en   = 1'b0;
                cfg_wr_data = '0;
                cfg_clear   = 1'b0;
                start       = 1'b0;
            end
            @(negedge clk);
        end
        check_idle({tag, "_after"}, 6'(n), 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("reset", 6'd0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_idle("reset_release", 6'd0, 1'b0);
    endtask

    task automatic test_empty_start();
        int run_seen;
        run_seen = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL empty_start done got=%b exp=1", done);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL empty_start busy got=%b exp=0", busy);
        end
        for (int k = 0; k < 6; k++) begin
            if (run !== 1'b0 || host_controller !== '0) run_seen++;
            @(negedge clk);
        end
        checks++;
        if (run_seen != 0) begin
            failures++;
            $display("[TB] FAIL empty_start activity got=%0d cycles exp=0", run_seen);
        end
        check_idle("empty_start_after", 6'd0, 1'b0);
    endtask

    task automatic test_collision();
        write_entry(exp_words[0]);
        write_entry(exp_words[1]);
        checks++;
        if (cnt !== 6'd2) begin
            failures++;
            $display("[TB] FAIL collision_load cnt got=%0d exp=2", cnt);
        end
        cfg_wr_en   = 1'b1;
        cfg_wr_data = 48'h1234_5678_9abc;
        run_replay(2, 1'b0, "collision");
        pulse_clear();
        check_idle("collision_clear", 6'd0, 1'b0);
    endtask

    task automatic test_sequence();
        load_eleven();
        checks++;
        if (cnt !== 6'd11) begin
            failures++;
            $display("[TB] FAIL seq_load cnt got=%0d exp=11", cnt);
        end
        run_replay(11, 1'b0, "seq_first");
    endtask

    task automatic test_back_to_back();
        run_replay(11, 1'b0, "seq_second");
        run_replay(11, 1'b0, "seq_third");
    endtask

    task automatic test_busy_ignore();
        run_replay(11, 1'b1, "busy_ignore");
        run_replay(11, 1'b0, "busy_ignore_replay");
    endtask

    task automatic test_overflow();
        pulse_clear();
        for (int i = 0; i < 32; i++) begin
            write_entry(48'h0000_1000_0000 + 48'(i));
        end
        checks++;
        if (cnt !== 6'd32 || ovf !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ovf_full cnt/ovf got=%0d/%b exp=32/0", cnt, ovf);
        end
        write_entry(48'h0000_2000_0000);
        checks++;
        if (cnt !== 6'd32) begin
            failures++;
            $display("[TB] FAIL ovf_drop cnt got=%0d exp=32", cnt);
        end
        checks++;
        if (ovf !== 1'b1) begin
            failures++;
            $display("[TB] FAIL ovf_drop ovf got=%b exp=1", ovf);
        end
        cfg_clear = 1'b1;
        start     = 1'b1;
        cfg_wr_en = 1'b1;
        @(negedge clk);
        cfg_clear = 1'b0;
        start     = 1'b0;
        cfg_wr_en = 1'b0;
        check_idle("ovf_clear", 6'd0, 1'b0);
        @(negedge clk);
        check_idle("ovf_clear_hold", 6'd0, 1'b0);
    endtask

    task automatic test_reset_mid_issue();
        load_eleven();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle("rst_mid_issue", 6'd0, 1'b0);
        @(negedge clk);
        check_idle("rst_mid_issue_hold", 6'd0, 1'b0);
        test_empty_start();
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        cfg_wr_en   = 1'b0;
        cfg_wr_data = '0;
        cfg_clear   = 1'b0;
        start       = 1'b0;

        exp_words[0]  = 48'h0047_0807_8d9f;
        exp_words[1]  = 48'h0052_1a03_4c11;
        exp_words[2]  = 48'h0013_7f00_22e0;
        exp_words[3]  = 48'h0064_0b1c_9a07;
        exp_words[4]  = 48'h0005_3e45_6f38;
        exp_words[5]  = 48'h4000_0100_a001;
        exp_words[6]  = 48'h4000_0200_a102;
        exp_words[7]  = 48'h4000_0400_a203;
        exp_words[8]  = 48'h4000_0800_a304;
        exp_words[9]  = 48'h4000_1000_a405;
        exp_words[10] = 48'h8000_0000_0001;

        @(negedge clk);
        test_reset();
        test_empty_start();
        test_collision();
        test_sequence();
        test_back_to_back();
        test_busy_ignore();
        test_overflow();
        test_reset_mid_issue();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
